// File: rtl/dcache_mem_responder.sv
// ----------------------------------------------------------------------------
// dcache_mem_responder
//
// Purpose:
//   Memory-side end of the L1 D-cache refill / store-through interface.
//   Line refills (dc2memLd*) are split into 64-bit beats on a request/grant
//   backing-memory port and reassembled into one line (mem2dcLd*).
//   Stores (dc2memSt*) are aligned into dword write + byte enables, buffered
//   in a small FIFO and written through. mem2dcStStall_o applies back-pressure
//   when the FIFO is full. A refill first waits for every buffered store to be
//   written, so a load never overtakes an older store.
//
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   dc2memLdAddr_i/Valid_i   refill block address + 1-cycle request pulse
//   mem2dcLdTag_o/Index_o    tag / index of the returned line
//   mem2dcLdData_o           returned line, beat k in [64k+63:64k]
//   mem2dcLdValid_o          1-cycle pulse when the line is presented
//   dc2memStAddr_i/Data_i    store byte address, LSB-aligned store data
//   dc2memStSize_i           log2(bytes): 0 B, 1 H, 2 W, 3 D, 4-7 illegal
//   dc2memStValid_i          store request (accepted when not stalled)
//   mem2dcStComplete_o       1-cycle pulse the cycle after a store is granted
//   mem2dcStStall_o          store FIFO full, stores are not accepted
//   mem_req_o/mem_we_o       backing memory request / write
//   mem_addr_o               dword-aligned byte address
//   mem_wdata_o/mem_be_o     write data / byte enables
//   mem_gnt_i                request accepted this cycle
//   mem_rvalid_i/mem_rdata_i read data, returned in request order
//
// Optional feature macro: DCRESP_PERF_CNT_EN
//   When defined, adds saturating 32-bit counters perfLdCnt_o (lines
//   returned), perfStCnt_o (stores completed), perfStallCnt_o (cycles a store
//   was presented while stalled).
// ----------------------------------------------------------------------------
module dcache_mem_responder #(
  parameter int BLK_ADDR_BITS = 59,
  parameter int INDEX_BITS    = 7,
  parameter int LINE_BITS     = 256,
  parameter int ST_ADDR_BITS  = 64,
  parameter int STQ_DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [BLK_ADDR_BITS-1:0]          dc2memLdAddr_i,
  input  logic                              dc2memLdValid_i,
  output logic [BLK_ADDR_BITS-INDEX_BITS-1:0] mem2dcLdTag_o,
  output logic [INDEX_BITS-1:0]             mem2dcLdIndex_o,
  output logic [LINE_BITS-1:0]              mem2dcLdData_o,
  output logic                              mem2dcLdValid_o,
  input  logic [ST_ADDR_BITS-1:0]           dc2memStAddr_i,
  input  logic [63:0]                       dc2memStData_i,
  input  logic [2:0]                        dc2memStSize_i,
  input  logic                              dc2memStValid_i,
  output logic                              mem2dcStComplete_o,
  output logic                              mem2dcStStall_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [63:0]                       mem_addr_o,
  output logic [63:0]                       mem_wdata_o,
  output logic [7:0]                        mem_be_o,
  input  logic                              mem_gnt_i,
  input  logic                              mem_rvalid_i,
  input  logic [63:0]                       mem_rdata_i
`ifdef DCRESP_PERF_CNT_EN
  ,
  output logic [31:0]                       perfLdCnt_o,
  output logic [31:0]                       perfStCnt_o,
  output logic [31:0]                       perfStallCnt_o
`endif
);

  localparam int BEATS    = LINE_BITS / 64;
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int PTR_W    = $clog2(STQ_DEPTH);
  localparam int CNT_W    = $clog2(STQ_DEPTH + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } ldState_e;

  // --------------------------------------------------------------------------
  // Store formatting helpers
  // --------------------------------------------------------------------------
  // Byte offset inside the dword with the bits below the access size cleared,
  // so a misaligned store is written at its natural alignment.
  function automatic logic [2:0] stOffset(input logic [2:0] addrLo,
                                          input logic [2:0] size);
    case (size)
      3'd0:    stOffset = addrLo;
      3'd1:    stOffset = {addrLo[2:1], 1'b0};
      3'd2:    stOffset = {addrLo[2], 2'b00};
      default: stOffset = 3'b000;
    endcase
  endfunction

  // Illegal sizes produce no byte enables; the write still goes out and
  // completes so the cache never waits on it.
  function automatic logic [7:0] stByteEn(input logic [2:0] size,
                                          input logic [2:0] off);
    case (size)
      3'd0:    stByteEn = 8'h01 << off;
      3'd1:    stByteEn = 8'h03 << off;
      3'd2:    stByteEn = 8'h0F << off;
      3'd3:    stByteEn = 8'hFF;
      default: stByteEn = 8'h00;
    endcase
  endfunction

  function automatic logic [63:0] stAlignData(input logic [63:0] data,
                                              input logic [2:0]  off);
    stAlignData = data << {off, 3'b000};
  endfunction

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  ldState_e                 state;
  logic [BLK_ADDR_BITS-1:0] blkAddrQ;
  logic [BEAT_W-1:0]        reqCnt;
  logic [BEAT_W-1:0]        rspCnt;
  logic [LINE_BITS-1:0]     lineBuf;
  logic [63:0]              rdAddr;
  logic                     beatLands;
  logic                     lastBeatLands;

  logic [ST_ADDR_BITS-1:0]  stqAddr [STQ_DEPTH];
  logic [63:0]              stqData [STQ_DEPTH];
  logic [7:0]               stqBe   [STQ_DEPTH];
  logic [PTR_W-1:0]         wrPtr;
  logic [PTR_W-1:0]         rdPtr;
  logic [CNT_W-1:0]         stqCnt;
  logic [CNT_W-1:0]         stqCntNext;
  logic [2:0]               stOff;
  logic                     stPush;
  logic                     stPop;
  logic                     stIssue;
  logic                     stqEmptyAfterPop;

  // --------------------------------------------------------------------------
  // Store queue control
  // --------------------------------------------------------------------------
  assign stOff            = stOffset(dc2memStAddr_i[2:0], dc2memStSize_i);
  assign stPush           = dc2memStValid_i && !mem2dcStStall_o;
  // Stores only own the memory port while no refill is in flight.
  assign stIssue          = (stqCnt != '0) && ((state == IDLE) || (state == DRAIN));
  assign stPop            = stIssue && mem_gnt_i;
  assign stqCntNext       = stqCnt + CNT_W'(stPush) - CNT_W'(stPop);
  // True when the queue is empty once this cycle's grant (if any) retires.
  assign stqEmptyAfterPop = (stqCnt == CNT_W'(stPop));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr              <= '0;
      rdPtr              <= '0;
      stqCnt             <= '0;
      mem2dcStStall_o    <= 1'b0;
      mem2dcStComplete_o <= 1'b0;
    end else begin
      if (stPush) wrPtr <= wrPtr + 1'b1;
      if (stPop)  rdPtr <= rdPtr + 1'b1;
      stqCnt             <= stqCntNext;
      // Stall comes from the next count so a push in the filling cycle is
      // already reflected and no store is ever dropped.
      mem2dcStStall_o    <= (stqCntNext == CNT_W'(STQ_DEPTH));
      mem2dcStComplete_o <= stPop;
    end
  end

  always_ff @(posedge clk) begin
    if (stPush) begin
      stqAddr[wrPtr] <= {dc2memStAddr_i[ST_ADDR_BITS-1:3], stOff};
      stqData[wrPtr] <= stAlignData(dc2memStData_i, stOff);
      stqBe[wrPtr]   <= stByteEn(dc2memStSize_i, stOff);
    end
  end

  // --------------------------------------------------------------------------
  // Memory port mux: refill beats in REQ, otherwise the store queue head
  // --------------------------------------------------------------------------
  assign rdAddr = (64'(blkAddrQ) << (BEAT_W + 3)) | (64'(reqCnt) << 3);

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 64'h0;
    mem_wdata_o = 64'h0;
    mem_be_o    = 8'h00;
    if (state == REQ) begin
      mem_req_o  = 1'b1;
      mem_addr_o = rdAddr;
    end else if (stIssue) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = 64'({stqAddr[rdPtr][ST_ADDR_BITS-1:3], 3'b000});
      mem_wdata_o = stqData[rdPtr];
      mem_be_o    = stqBe[rdPtr];
    end
  end

  // --------------------------------------------------------------------------
  // Refill FSM
  // --------------------------------------------------------------------------
  assign beatLands     = mem_rvalid_i && ((state == REQ) || (state == WAIT));
  assign lastBeatLands = beatLands && (rspCnt == LAST_BEAT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      reqCnt          <= '0;
      rspCnt          <= '0;
      mem2dcLdValid_o <= 1'b0;
      mem2dcLdTag_o   <= '0;
      mem2dcLdIndex_o <= '0;
      mem2dcLdData_o  <= '0;
    end else begin
      mem2dcLdValid_o <= 1'b0;
      if (beatLands) rspCnt <= rspCnt + 1'b1;
      case (state)
        IDLE: begin
          if (dc2memLdValid_i) state <= stqEmptyAfterPop ? REQ : DRAIN;
        end
        DRAIN: begin
          if (stqEmptyAfterPop) state <= REQ;
        end
        REQ: begin
          if (mem_gnt_i) begin
            reqCnt <= reqCnt + 1'b1;
            // Zero-latency memory can land the last beat with the last grant.
            if (reqCnt == LAST_BEAT) state <= lastBeatLands ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (lastBeatLands) state <= RESP;
        end
        RESP: begin
          mem2dcLdValid_o <= 1'b1;
          mem2dcLdTag_o   <= blkAddrQ[BLK_ADDR_BITS-1:INDEX_BITS];
          mem2dcLdIndex_o <= blkAddrQ[INDEX_BITS-1:0];
          mem2dcLdData_o  <= lineBuf;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && dc2memLdValid_i) blkAddrQ <= dc2memLdAddr_i;
    if (beatLands) lineBuf[{rspCnt, 6'b000000} +: 64] <= mem_rdata_i;
  end

  // A refill request while one is already in flight is a cache-side bug.
  ldReqOnlyInIdle: assert property (@(posedge clk) disable iff (!reset_n)
    dc2memLdValid_i |-> (state == IDLE));

`ifdef DCRESP_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters (saturating)
  // --------------------------------------------------------------------------
  function automatic logic [31:0] satInc(input logic [31:0] v);
    satInc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perfLdCnt_o    <= 32'd0;
      perfStCnt_o    <= 32'd0;
      perfStallCnt_o <= 32'd0;
    end else begin
      if (state == RESP)                        perfLdCnt_o    <= satInc(perfLdCnt_o);
      if (mem2dcStComplete_o)                   perfStCnt_o    <= satInc(perfStCnt_o);
      if (mem2dcStStall_o && dc2memStValid_i)   perfStallCnt_o <= satInc(perfStallCnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_dcache_mem_responder
//
// Directed bench for dcache_mem_responder. A small behavioural memory grants
// when gnt is set, returns read data one cycle after a read grant (beat k of
// a line reads as (k+1)*0x1111111111111111) and logs every granted access.
// ----------------------------------------------------------------------------
module tb_dcache_mem_responder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [58:0]  dc2memLdAddr_i = '0;
  logic         dc2memLdValid_i = 1'b0;
  logic [51:0]  mem2dcLdTag_o;
  logic [6:0]   mem2dcLdIndex_o;
  logic [255:0] mem2dcLdData_o;
  logic         mem2dcLdValid_o;
  logic [63:0]  dc2memStAddr_i = '0;
  logic [63:0]  dc2memStData_i = '0;
  logic [2:0]   dc2memStSize_i = '0;
  logic         dc2memStValid_i = 1'b0;
  logic         mem2dcStComplete_o;
  logic         mem2dcStStall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [63:0]  mem_addr_o;
  logic [63:0]  mem_wdata_o;
  logic [7:0]   mem_be_o;
  logic         gnt = 1'b1;
  logic         mem_rvalid_i = 1'b0;
  logic [63:0]  mem_rdata_i = '0;
`ifdef DCRESP_PERF_CNT_EN
  logic [31:0]  perfLdCnt;
  logic [31:0]  perfStCnt;
  logic [31:0]  perfStallCnt;
`endif

  localparam logic [255:0] LINE_PAT =
    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;

  dcache_mem_responder dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .dc2memLdAddr_i     (dc2memLdAddr_i),
    .dc2memLdValid_i    (dc2memLdValid_i),
    .mem2dcLdTag_o      (mem2dcLdTag_o),
    .mem2dcLdIndex_o    (mem2dcLdIndex_o),
    .mem2dcLdData_o     (mem2dcLdData_o),
    .mem2dcLdValid_o    (mem2dcLdValid_o),
    .dc2memStAddr_i     (dc2memStAddr_i),
    .dc2memStData_i     (dc2memStData_i),
    .dc2memStSize_i     (dc2memStSize_i),
    .dc2memStValid_i    (dc2memStValid_i),
    .mem2dcStComplete_o (mem2dcStComplete_o),
    .mem2dcStStall_o    (mem2dcStStall_o),
    .mem_req_o          (mem_req_o),
    .mem_we_o           (mem_we_o),
    .mem_addr_o         (mem_addr_o),
    .mem_wdata_o        (mem_wdata_o),
    .mem_be_o           (mem_be_o),
    .mem_gnt_i          (gnt),
    .mem_rvalid_i       (mem_rvalid_i),
    .mem_rdata_i        (mem_rdata_i)
`ifdef DCRESP_PERF_CNT_EN
    ,
    .perfLdCnt_o        (perfLdCnt),
    .perfStCnt_o        (perfStCnt),
    .perfStallCnt_o     (perfStallCnt)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int ldPulses = 0;
  int cmplPulses = 0;

  logic        logWe   [$];
  logic [63:0] logAddr [$];
  logic [63:0] logData [$];
  logic [7:0]  logBe   [$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] beatPattern(input logic [63:0] a);
    logic [63:0] k;
    k = {62'b0, a[4:3]} + 64'd1;
    return k * 64'h1111_1111_1111_1111;
  endfunction

  // Behavioural memory: sample the request at the edge, answer 1 cycle later.
  always @(posedge clk) begin
    logic        fire;
    logic [63:0] a;
    fire = mem_req_o && gnt && !mem_we_o;
    a    = mem_addr_o;
    if (mem_req_o && gnt) begin
      logWe.push_back(mem_we_o);
      logAddr.push_back(mem_addr_o);
      logData.push_back(mem_wdata_o);
      logBe.push_back(mem_be_o);
    end
    if (mem2dcLdValid_o)    ldPulses++;
    if (mem2dcStComplete_o) cmplPulses++;
    #1;
    mem_rvalid_i = fire;
    mem_rdata_i  = fire ? beatPattern(a) : 64'h0;
  end

  task automatic clearLog();
    logWe.delete(); logAddr.delete(); logData.delete(); logBe.delete();
  endtask

  // Issue a refill and measure cycles from the request cycle to the valid pulse.
  task automatic ldRefill(input logic [58:0] blk, output int lat,
                          output logic [51:0] tag, output logic [6:0] idx,
                          output logic [255:0] line);
    lat = -1; tag = '0; idx = '0; line = '0;
    @(negedge clk);
    dc2memLdAddr_i  = blk;
    dc2memLdValid_i = 1'b1;
    @(negedge clk);
    dc2memLdValid_i = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (mem2dcLdValid_o) begin
        lat = i; tag = mem2dcLdTag_o; idx = mem2dcLdIndex_o; line = mem2dcLdData_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic stDrive(input logic [63:0] a, input logic [63:0] d, input logic [2:0] sz);
    @(negedge clk);
    dc2memStAddr_i  = a;
    dc2memStData_i  = d;
    dc2memStSize_i  = sz;
    dc2memStValid_i = 1'b1;
    @(negedge clk);
    dc2memStValid_i = 1'b0;
  endtask

  initial begin
    int           lat;
    int           c0;
    int           p0;
    logic [51:0]  tag;
    logic [6:0]   idx;
    logic [255:0] line;
    logic [63:0]  tAddr [4];
    logic [63:0]  tData [4];
    logic [2:0]   tSize [4];
    logic [63:0]  eAddr [4];
    logic [63:0]  eData [4];
    logic [7:0]   eBe   [4];

    tAddr[0] = 64'h4003; tData[0] = 64'h1234;             tSize[0] = 3'd1;
    eAddr[0] = 64'h4000; eData[0] = 64'h1234_0000;        eBe[0] = 8'h0C;
    tAddr[1] = 64'h3006; tData[1] = 64'hDEAD_BEEF;        tSize[1] = 3'd2;
    eAddr[1] = 64'h3000; eData[1] = 64'hDEAD_BEEF_0000_0000; eBe[1] = 8'hF0;
    tAddr[2] = 64'h2007; tData[2] = 64'h0123_4567_89AB_CDEF; tSize[2] = 3'd3;
    eAddr[2] = 64'h2000; eData[2] = 64'h0123_4567_89AB_CDEF; eBe[2] = 8'hFF;
    tAddr[3] = 64'h5008; tData[3] = 64'h55;               tSize[3] = 3'd5;
    eAddr[3] = 64'h5008; eData[3] = 64'h0;                eBe[3] = 8'h00;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("rst_ldValid",  mem2dcLdValid_o, 0);
    chk("rst_stall",    mem2dcStStall_o, 0);
    chk("rst_complete", mem2dcStComplete_o, 0);
    chk("rst_memReq",   mem_req_o, 0);
    chk("rst_ldData",   mem2dcLdData_o, 0);
    reset_n = 1'b1;

    // ---------------- basic refill ----------------
    clearLog();
    ldRefill(59'h40, lat, tag, idx, line);
    chk("ref_latency", lat, 7);
    chk("ref_index",   idx, 7'h40);
    chk("ref_tag",     tag, 0);
    chk("ref_data",    line, LINE_PAT);
    @(negedge clk);
    chk("ref_pulse1cyc", mem2dcLdValid_o, 0);
    chk("ref_nReads", logAddr.size(), 4);
    for (int k = 0; k < 4 && k < logAddr.size(); k++) begin
      chk($sformatf("ref_rdAddr%0d", k), logAddr[k], 64'h800 + 64'(8 * k));
      chk($sformatf("ref_rdWe%0d", k), logWe[k], 0);
    end

    // ---------------- single byte store, detailed timing ----------------
    clearLog();
    c0 = cmplPulses;
    @(negedge clk);
    dc2memStAddr_i = 64'h1005; dc2memStData_i = 64'hAB; dc2memStSize_i = 3'd0;
    dc2memStValid_i = 1'b1;
    @(negedge clk);
    dc2memStValid_i = 1'b0;
    chk("stB_req",   mem_req_o, 1);
    chk("stB_we",    mem_we_o, 1);
    chk("stB_addr",  mem_addr_o, 64'h1000);
    chk("stB_be",    mem_be_o, 8'h20);
    chk("stB_wdata", mem_wdata_o, 64'h0000_AB00_0000_0000);
    chk("stB_cmplEarly", mem2dcStComplete_o, 0);
    @(negedge clk);
    chk("stB_cmpl",  mem2dcStComplete_o, 1);
    @(negedge clk);
    chk("stB_cmplPulse", mem2dcStComplete_o, 0);
    chk("stB_cmplCnt", cmplPulses - c0, 1);

    // ---------------- store formatting table ----------------
    clearLog();
    c0 = cmplPulses;
    for (int i = 0; i < 4; i++) begin
      stDrive(tAddr[i], tData[i], tSize[i]);
      repeat (2) @(negedge clk);
    end
    chk("stT_nWrites", logAddr.size(), 4);
    chk("stT_cmplCnt", cmplPulses - c0, 4);
    for (int i = 0; i < 4 && i < logAddr.size(); i++) begin
      chk($sformatf("stT_addr%0d", i), logAddr[i], eAddr[i]);
      chk($sformatf("stT_be%0d", i), logBe[i], eBe[i]);
      if (i < 3) chk($sformatf("stT_wdata%0d", i), logData[i], eData[i]);
    end

    // ---------------- back-pressure: 5 stores, grant held off ----------------
    clearLog();
    c0 = cmplPulses;
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dc2memStAddr_i = 64'h6000 + 64'(8 * i); dc2memStData_i = 64'h100 + 64'(i);
      dc2memStSize_i = 3'd3; dc2memStValid_i = 1'b1;
    end
    @(negedge clk);
    chk("bp_stallAfter4", mem2dcStStall_o, 1);
    dc2memStAddr_i = 64'h6020; dc2memStData_i = 64'h104;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_stallHeld%0d", i), mem2dcStStall_o, 1);
    end
    chk("bp_noGrant", logAddr.size(), 0);
    gnt = 1'b1;
    p0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!mem2dcStStall_o) begin
        @(negedge clk);
        dc2memStValid_i = 1'b0;
        p0 = 1;
        break;
      end
    end
    dc2memStValid_i = 1'b0;
    chk("bp_stallReleased", p0, 1);
    for (int i = 0; i < 20 && (cmplPulses - c0) < 5; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("bp_cmplCnt", cmplPulses - c0, 5);
    chk("bp_nWrites", logAddr.size(), 5);
    for (int i = 0; i < 5 && i < logData.size(); i++)
      chk($sformatf("bp_order%0d", i), logData[i], 64'h100 + 64'(i));
`ifdef DCRESP_PERF_CNT_EN
    chk("perf_stall4", perfStallCnt, 4);
    chk("perf_st10",   perfStCnt, 10);
    chk("perf_ld1",    perfLdCnt, 1);
`endif

    // ---------------- refill drains older stores first ----------------
    clearLog();
    gnt = 1'b0;
    stDrive(64'h7000, 64'hA1, 3'd3);
    stDrive(64'h7008, 64'hA2, 3'd3);
    @(negedge clk);
    dc2memLdAddr_i = 59'h41; dc2memLdValid_i = 1'b1;
    @(negedge clk);
    dc2memLdValid_i = 1'b0;
    gnt = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (mem2dcLdValid_o) begin
        lat = i; idx = mem2dcLdIndex_o; line = mem2dcLdData_o;
        break;
      end
      @(negedge clk);
    end
    chk("dr_ldSeen",  lat >= 0, 1);
    chk("dr_index",   idx, 7'h41);
    chk("dr_data",    line, LINE_PAT);
    chk("dr_nAccess", logAddr.size(), 6);
    if (logAddr.size() >= 3) begin
      chk("dr_first_we",  logWe[0], 1);
      chk("dr_first_adr", logAddr[0], 64'h7000);
      chk("dr_second_we", logWe[1], 1);
      chk("dr_second_adr", logAddr[1], 64'h7008);
      chk("dr_read_we",   logWe[2], 0);
      chk("dr_read_adr",  logAddr[2], 64'h820);
    end

    // ---------------- reset in the middle of a refill ----------------
    @(negedge clk);
    dc2memLdAddr_i = 59'h42; dc2memLdValid_i = 1'b1;
    @(negedge clk);
    dc2memLdValid_i = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mr_ldValid", mem2dcLdValid_o, 0);
    chk("mr_memReq",  mem_req_o, 0);
    chk("mr_ldData",  mem2dcLdData_o, 0);
    chk("mr_ldIndex", mem2dcLdIndex_o, 0);
    chk("mr_stall",   mem2dcStStall_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    p0 = ldPulses;
    repeat (12) @(negedge clk);
    chk("mr_noLdValid", ldPulses - p0, 0);
    ldRefill(59'h12345, lat, tag, idx, line);
    chk("mr_latency", lat, 7);
    chk("mr_tag",     tag, 52'h246);
    chk("mr_index",   idx, 7'h45);
    chk("mr_data",    line, LINE_PAT);

`ifdef DCRESP_PERF_CNT_EN
    ldRefill(59'h43, lat, tag, idx, line);
    ldRefill(59'h44, lat, tag, idx, line);
    stDrive(64'h8000, 64'h1, 3'd3);
    stDrive(64'h8008, 64'h2, 3'd3);
    repeat (3) @(negedge clk);
    chk("perf_ld3",    perfLdCnt, 3);
    chk("perf_st2",    perfStCnt, 2);
    chk("perf_stall0", perfStallCnt, 0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
